// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_seq
// Brief    : Digit-by-digit integer square root, one root bit per clock.
//            Optional `exact` flag output built when ISQRT_EXACT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_seq #(
    parameter  int IN_W  = 6,
    localparam int OUT_W = IN_W / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  a,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] root,
    output logic [OUT_W:0]   rem
`ifdef ISQRT_EXACT_EN
    ,
    output logic             exact
`endif
);

    localparam int RW    = OUT_W + 2;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    opd_q, opd_d;
    logic [RW-1:0]      rem_acc_q, rem_acc_d;
    logic [OUT_W-1:0]   root_acc_q, root_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   root_q, root_d;
    logic [OUT_W:0]     rem_q, rem_d;

    logic [RW-1:0]      w_acc;
    logic [RW-1:0]      w_trial;
    logic               w_ge;
    logic [RW-1:0]      w_rem_nxt;
    logic [OUT_W-1:0]   w_root_nxt;

    // One restoring step: bring down the next two operand bits and try 4*root+1.
    assign w_acc      = (rem_acc_q << 2) | RW'(opd_q[IN_W-1 -: 2]);
    assign w_trial    = {root_acc_q, 2'b01};
    assign w_ge       = (w_acc >= w_trial);
    assign w_rem_nxt  = w_ge ? (w_acc - w_trial) : w_acc;
    assign w_root_nxt = (root_acc_q << 1) | OUT_W'(w_ge);

    always_comb begin
        state_d    = state_q;
        opd_d      = opd_q;
        rem_acc_d  = rem_acc_q;
        root_acc_d = root_acc_q;
        cnt_d      = cnt_q;
        root_d     = root_q;
        rem_d      = rem_q;
        case (state_q)
            CALC: begin
                opd_d      = opd_q << 2;
                rem_acc_d  = w_rem_nxt;
                root_acc_d = w_root_nxt;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = DONE;
                    root_d  = w_root_nxt;
                    rem_d   = w_rem_nxt[OUT_W:0];
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    state_d    = CALC;
                    opd_d      = a;
                    rem_acc_d  = '0;
                    root_acc_d = '0;
                    cnt_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opd_q      <= '0;
            rem_acc_q  <= '0;
            root_acc_q <= '0;
            cnt_q      <= '0;
            root_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            opd_q      <= opd_d;
            rem_acc_q  <= rem_acc_d;
            root_acc_q <= root_acc_d;
            cnt_q      <= cnt_d;
            root_q     <= root_d;
            rem_q      <= rem_d;
        end
    end

`ifdef ISQRT_EXACT_EN
    logic exact_q;

    // Evaluated from the final remainder so it lands in the same cycle as root.
    always_ff @(posedge clk) begin
        if (rst) begin
            exact_q <= 1'b0;
        end else if (state_q == CALC && cnt_q == C_LAST) begin
            exact_q <= (w_rem_nxt[OUT_W:0] == '0);
        end
    end

    assign exact = exact_q;
`endif

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign root = root_q;
    assign rem  = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_isqrt_seq
// Brief    : Self-checking bench for isqrt_seq against a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_seq;

`ifdef ISQRT_EXACT_EN
    localparam int IN_W = 8;
`else
    localparam int IN_W = 6;
`endif
    localparam int OUT_W = IN_W / 2;
    localparam int MAXA  = (1 << IN_W) - 1;
    localparam int BOUND = 4 * OUT_W + 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IN_W-1:0]  a = '0;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] root;
    logic [OUT_W:0]   rem;
`ifdef ISQRT_EXACT_EN
    logic             exact;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    isqrt_seq #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .root  (root),
        .rem   (rem)
`ifdef ISQRT_EXACT_EN
        ,
        .exact (exact)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_sqrt(input longint v, output longint r, output longint m);
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        m = v - r * r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; returns once done is seen.
    task automatic wait_done(input string tag, output int cycles, output int bcyc);
        cycles = 0;
        bcyc   = 0;
        while (!done && cycles < BOUND) begin
            check({tag, "_busy_done_excl"}, longint'(busy & done), 0);
            if (busy) bcyc++;
            tick();
            cycles++;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        check({tag, "_busy_in_done"}, longint'(busy), 0);
    endtask

    task automatic check_result(input string tag, input longint v);
        longint r, m;
        ref_sqrt(v, r, m);
        check({tag, "_root"}, longint'(root), r);
        check({tag, "_rem"},  longint'(rem),  m);
`ifdef ISQRT_EXACT_EN
        check({tag, "_exact"}, longint'(exact), longint'(m == 0));
`endif
    endtask

    task automatic do_op(input string tag, input int unsigned v);
        int c, b;
        start = 1'b1;
        a     = v[IN_W-1:0];
        tick();
        start = 1'b0;
        a     = IN_W'($urandom);
        wait_done(tag, c, b);
        check({tag, "_latency"}, c, OUT_W);
        check({tag, "_busy_cycles"}, b, OUT_W);
        check_result(tag, v);
    endtask

    initial begin
        int c, b, nd;
        longint r, m;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_root", longint'(root), 0);
        check("rst_rem",  longint'(rem),  0);
`ifdef ISQRT_EXACT_EN
        check("rst_exact", longint'(exact), 0);
`endif

        // Basic operation and boundaries
        do_op("a49", 49);
        check("a49_root_const", longint'(root), 7);
        check("a49_rem_const",  longint'(rem),  0);
        tick();
        check("done_pulse_low", longint'(done), 0);
        check("hold_root_idle", longint'(root), 7);

        do_op("a0", 0);
        check("a0_root_const", longint'(root), 0);
        do_op("amax", MAXA);
        check("amax_root_const", longint'(root), (1 << OUT_W) - 1);
        check("amax_rem_const",  longint'(rem),  (1 << (OUT_W + 1)) - 2);
        do_op("a50", 50);

        // Exhaustive, back-to-back with start held high
        start = 1'b1;
        a     = '0;
        tick();
        for (int v = 0; v <= MAXA; v++) begin
            wait_done("b2b", c, b);
            check("b2b_latency", c, OUT_W);
            check_result("b2b", v);
            check("b2b_identity", longint'(root) * longint'(root) + longint'(rem), v);
            check("b2b_rem_bound", longint'(rem <= 2 * root), 1);
            if (v < MAXA) a = IN_W'(v + 1);
            else          start = 1'b0;
            tick();
            if (v < MAXA) check("b2b_rearm_busy", longint'(busy), 1);
        end

        // Squarer outputs invert to their operand
        for (int x = 0; x < (1 << OUT_W); x++) begin
            do_op("sq", x * x);
            check("sq_root_op", longint'(root), x);
            check("sq_rem_zero", longint'(rem), 0);
        end

        // start during CALC is ignored
        start = 1'b1;
        a     = IN_W'(36);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        a     = IN_W'(9);
        tick();
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                nd++;
                check("ign_root", longint'(root), 6);
                check("ign_rem",  longint'(rem),  0);
            end
            tick();
        end
        check("ign_done_count", nd, 1);

        // Reset mid-CALC
        start = 1'b1;
        a     = IN_W'(MAXA);
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_root", longint'(root), 0);
        check("midrst_rem",  longint'(rem),  0);
        do_op("a16", 16);
        check("a16_root_const", longint'(root), 4);

`ifdef ISQRT_EXACT_EN
        do_op("a225", 225);
        check("a225_root_const", longint'(root), 15);
        check("a225_exact_const", longint'(exact), 1);
        do_op("a255", 255);
        check("a255_rem_const", longint'(rem), 30);
        check("a255_exact_const", longint'(exact), 0);
`endif

        // Randomized operands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            int unsigned v;
            v = $urandom_range(MAXA, 0);
            do_op("rnd", v);
            ref_sqrt(longint'(v), r, m);
            check("rnd_identity", longint'(root) * longint'(root) + longint'(rem), longint'(v));
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
